// File: rtl/dm_port_arbiter_pkg.sv
// Shared constants, types and the lane-reverse helper for the two-port line
// data memory arbiter.
package dm_port_arbiter_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned LINE_W = 256;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned LANES  = LINE_W / WORD_W;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [LINE_W-1:0] line_t;
    typedef logic [LANES-1:0]  mask_t;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    typedef struct packed {
        port_e port;
        logic  we;
        addr_t addr;
        line_t wdata;
        mask_t wmask;
    } slot_t;

    // The memory returns word i in the top-down lane position; swap so lane i is word i.
    function automatic line_t lane_reverse(input line_t x);
        line_t r;
        r = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            r[i*WORD_W +: WORD_W] = x[(LANES-1-i)*WORD_W +: WORD_W];
        end
        return r;
    endfunction

endpackage

// File: rtl/dm_port_arbiter_if.sv
// Requester handshake/response bundle and the line memory bundle used by the
// data memory port arbiter.
interface dm_req_if;
    import dm_port_arbiter_pkg::*;

    logic  valid;
    logic  ready;
    logic  we;
    addr_t addr;
    line_t wdata;
    mask_t wmask;
    logic  rsp_valid;
    line_t rsp_rdata;

    modport master (
        output valid, we, addr, wdata, wmask,
        input  ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  valid, we, addr, wdata, wmask,
        output ready, rsp_valid, rsp_rdata
    );
endinterface

interface dm_mem_if;
    import dm_port_arbiter_pkg::*;

    logic  wen;
    addr_t addr;
    line_t wdata;
    line_t rdata;

    modport master (
        output wen, addr, wdata,
        input  rdata
    );

    modport slave (
        input  wen, addr, wdata,
        output rdata
    );
endinterface

// File: rtl/dm_lane_merge.sv
// Combinational read-merge path: restores requester lane order on the memory
// read data and overlays the masked write lanes.
module dm_lane_merge
    import dm_port_arbiter_pkg::*;
(
    input  line_t mem_rdata_i,
    input  line_t wdata_i,
    input  mask_t wmask_i,
    output line_t old_line_o,
    output line_t merged_line_o
);

    line_t old_line;

    assign old_line   = lane_reverse(mem_rdata_i);
    assign old_line_o = old_line;

    always_comb begin
        merged_line_o = old_line;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (wmask_i[i]) begin
                merged_line_o[i*WORD_W +: WORD_W] = wdata_i[i*WORD_W +: WORD_W];
            end
        end
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Round-robin two-port front end for the line data memory: one request slot,
// single-cycle read-merge-write access and a registered per-port response.
module dm_port_arbiter
    import dm_port_arbiter_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    dm_req_if.slave  p0,
    dm_req_if.slave  p1,
    dm_mem_if.master mem
);

    slot_state_e state_q;
    slot_t       slot_q;
    slot_t       slot_d;
    port_e       rr_last_q;
    logic        rsp0_valid_q;
    logic        rsp1_valid_q;
    line_t       rsp0_rdata_q;
    line_t       rsp1_rdata_q;

    logic        gnt0;
    logic        gnt1;
    logic        accept;
    logic        access_en;
    port_e       acc_port;
    line_t       old_line;
    line_t       merged_line;

    // On contention the port that did not win last time is served.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (p0.valid && p1.valid) begin
                gnt0 = (rr_last_q == PORT1);
                gnt1 = (rr_last_q == PORT0);
            end else begin
                gnt0 = p0.valid;
                gnt1 = p1.valid;
            end
        end
    end

    assign accept    = gnt0 || gnt1;
    assign acc_port  = gnt1 ? PORT1 : PORT0;
    assign access_en = (state_q == SLOT_FULL) && !rst;

    assign p0.ready = gnt0;
    assign p1.ready = gnt1;

    always_comb begin
        slot_d = slot_q;
        if (accept) begin
            slot_d.port = acc_port;
            if (acc_port == PORT1) begin
                slot_d.we    = p1.we;
                slot_d.addr  = p1.addr;
                slot_d.wdata = p1.wdata;
                slot_d.wmask = p1.wmask;
            end else begin
                slot_d.we    = p0.we;
                slot_d.addr  = p0.addr;
                slot_d.wdata = p0.wdata;
                slot_d.wmask = p0.wmask;
            end
        end
    end

    dm_lane_merge u_merge (
        .mem_rdata_i   (mem.rdata),
        .wdata_i       (slot_q.wdata),
        .wmask_i       (slot_q.wmask),
        .old_line_o    (old_line),
        .merged_line_o (merged_line)
    );

    // The slot address is only overwritten on acceptance, so it doubles as the held memory address.
    assign mem.addr  = slot_q.addr;
    assign mem.wen   = access_en && slot_q.we && (|slot_q.wmask);
    assign mem.wdata = access_en ? merged_line : '0;

    assign p0.rsp_valid = rsp0_valid_q;
    assign p0.rsp_rdata = rsp0_rdata_q;
    assign p1.rsp_valid = rsp1_valid_q;
    assign p1.rsp_rdata = rsp1_rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SLOT_EMPTY;
            slot_q       <= '0;
            rr_last_q    <= PORT1;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            rsp0_valid_q <= access_en && (slot_q.port == PORT0);
            rsp1_valid_q <= access_en && (slot_q.port == PORT1);
            if (access_en && (slot_q.port == PORT0)) begin
                rsp0_rdata_q <= old_line;
            end
            if (access_en && (slot_q.port == PORT1)) begin
                rsp1_rdata_q <= old_line;
            end
            slot_q <= slot_d;
            if (accept) begin
                state_q   <= SLOT_FULL;
                rr_last_q <= acc_port;
            end else begin
                state_q   <= SLOT_EMPTY;
            end
        end
    end

endmodule
